// File: rtl/updn_cmd_conditioner_pkg.sv
// Shared types and default timing for the up/down command conditioner.
// Button FSM encoding, button slot indices and a sizing helper for the counters.
package updn_cmd_conditioner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_DEB,
    ST_HELD,
    ST_REPEAT,
    ST_RELEASE_DEB
  } btn_state_e;

  localparam int DEF_WIDTH         = 5;
  localparam int DEF_DEB_CYCLES    = 4;
  localparam int DEF_REPEAT_DELAY  = 16;
  localparam int DEF_REPEAT_PERIOD = 4;

  localparam int NUM_BTN  = 3;
  localparam int BTN_LOAD = 0;
  localparam int BTN_UP   = 1;
  localparam int BTN_DOWN = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/updn_cmd_conditioner_btn_conditioner.sv
// One push-button: 2-flop synchronizer, debounce and optional auto-repeat.
// Emits a registered single-cycle request per accepted press or repeat tick.
module btn_conditioner
  import updn_cmd_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_req
);

  localparam int CNT_MAX = max3(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);
  localparam logic [CW-1:0] DEB_C   = CW'(DEB_CYCLES);
  localparam logic [CW-1:0] DLY_C   = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PER_C   = CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic          r_meta;
  logic          r_sync;
  btn_state_e    r_state;
  btn_state_e    r_ret_state;
  logic [CW-1:0] r_deb_cnt;
  logic [CW-1:0] r_tmr_cnt;
  logic          r_req;
  logic [CW-1:0] w_tmr_limit;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_TOP) ? v : v + 1'b1;
  endfunction

  assign w_tmr_limit = (r_state == ST_HELD) ? DLY_C : PER_C;
  assign o_req       = r_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta      <= 1'b0;
      r_sync      <= 1'b0;
      r_state     <= ST_IDLE;
      r_ret_state <= ST_HELD;
      r_deb_cnt   <= '0;
      r_tmr_cnt   <= '0;
      r_req       <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_req  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_sync) begin
            r_state   <= ST_PRESS_DEB;
            r_deb_cnt <= ONE_C;
          end
        end
        ST_PRESS_DEB: begin
          // The count already holds DEB_CYCLES stable samples, so accept now.
          if (r_deb_cnt >= DEB_C) begin
            r_state     <= ST_HELD;
            r_ret_state <= ST_HELD;
            r_deb_cnt   <= '0;
            r_tmr_cnt   <= ONE_C;
            r_req       <= 1'b1;
          end else if (!r_sync) begin
            r_state   <= ST_IDLE;
            r_deb_cnt <= '0;
          end else begin
            r_deb_cnt <= sat_inc(r_deb_cnt);
          end
        end
        ST_HELD, ST_REPEAT: begin
          if (!r_sync) begin
            r_state     <= ST_RELEASE_DEB;
            r_ret_state <= r_state;
            r_deb_cnt   <= ONE_C;
          end else if (REPEAT_EN && (r_tmr_cnt >= w_tmr_limit)) begin
            r_state   <= ST_REPEAT;
            r_tmr_cnt <= ONE_C;
            r_req     <= 1'b1;
          end else begin
            r_tmr_cnt <= sat_inc(r_tmr_cnt);
          end
        end
        ST_RELEASE_DEB: begin
          // A bounce back to 1 resumes the held/repeat timer where it paused.
          if (r_sync) begin
            r_state   <= r_ret_state;
            r_deb_cnt <= '0;
          end else if (r_deb_cnt >= DEB_C) begin
            r_state   <= ST_IDLE;
            r_deb_cnt <= '0;
            r_tmr_cnt <= '0;
          end else begin
            r_deb_cnt <= sat_inc(r_deb_cnt);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/updn_cmd_conditioner.sv
// Turns raw load/up/down buttons and switches into clean counter commands.
// Priority load > down > up; saturating up/down requests are discarded.
module updn_cmd_conditioner
  import updn_cmd_conditioner_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_btn_load,
  input  logic             i_btn_up,
  input  logic             i_btn_down,
  input  logic [WIDTH-1:0] i_sw_value,
  input  logic             i_high,
  input  logic             i_low,
  output logic [WIDTH-1:0] o_in,
  output logic             o_load,
  output logic             o_up,
  output logic             o_down
);

  logic [NUM_BTN-1:0] w_btn_raw;
  logic [NUM_BTN-1:0] w_req;
  logic               w_down_ok;
  logic               w_up_ok;
  logic [WIDTH-1:0]   r_sw_meta;
  logic [WIDTH-1:0]   r_sw_sync;
  logic [WIDTH-1:0]   r_in;
  logic               r_load;
  logic               r_up;
  logic               r_down;

  assign w_btn_raw = {i_btn_down, i_btn_up, i_btn_load};

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_conditioner #(
        .DEB_CYCLES   (DEB_CYCLES),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD),
        .REPEAT_EN    (gi != BTN_LOAD)
      ) u_btn (
        .clk  (clk),
        .rst  (rst),
        .i_btn(w_btn_raw[gi]),
        .o_req(w_req[gi])
      );
    end
  endgenerate

  // Guard is applied before arbitration; a guarded request never blocks another.
  assign w_down_ok = w_req[BTN_DOWN] & ~i_low;
  assign w_up_ok   = w_req[BTN_UP] & ~i_high;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_in      <= '0;
      r_load    <= 1'b0;
      r_up      <= 1'b0;
      r_down    <= 1'b0;
    end else begin
      r_sw_meta <= i_sw_value;
      r_sw_sync <= r_sw_meta;
      r_load    <= w_req[BTN_LOAD];
      r_down    <= ~w_req[BTN_LOAD] & w_down_ok;
      r_up      <= ~w_req[BTN_LOAD] & ~w_down_ok & w_up_ok;
      if (w_req[BTN_LOAD]) begin
        r_in <= r_sw_sync;
      end
    end
  end

  assign o_in   = r_in;
  assign o_load = r_load;
  assign o_up   = r_up;
  assign o_down = r_down;

endmodule
